spi_slave: RTL
==============

Name: spi_slave

Overview:
SPI mode-0 (CPOL=0, CPHA=0) slave. It is the receiving end of the link driven by spi_master.
- Oversamples sck, cs_n and mosi on the local system clock.
- Assembles MSB-first words and presents each one with a one-cycle valid strobe.
- Shifts a reply word out on miso.
- Used as the on-chip peer for loopback testing of spi_master and as the register-access front end of peripheral blocks.

Parameters:
DATA_W, 8, word width in bits (must be at least 2).
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (must be at least 2).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
sck  in  1  SPI serial clock from the master, asynchronous to clk.
cs_n  in  1  SPI chip select, active-low, asynchronous.
mosi  in  1  master-out data, asynchronous.
miso  out  1  slave-out data.
tx_data  in  DATA_W  reply word; sampled at each word boundary.
rx_data  out  DATA_W  last completed received word.
rx_valid  out  1  one-cycle pulse when rx_data updates.
frame_err  out  1  one-cycle pulse when cs_n deasserts mid-word.
busy  out  1  high while the synchronized cs_n is asserted.

Behaviour:
- Reset: rst=1 at a clk edge gives:
  - miso=0, rx_data=0, rx_valid=0, frame_err=0, busy=0;
  - bit counter=0, state IDLE;
  - every synchronizer stage loaded to its idle level (sck=0, cs_n=1, mosi=0).
  - Reset wins over every other event, including reset in the middle of a frame. No rx_valid or frame_err is emitted for the aborted frame.
- Input handling:
  - sck, cs_n and mosi each pass through a SYNC_STAGES flip-flop chain.
  - The edge detector compares the last synchronizer stage with one extra register.
  - Timing requirement on the master: sck high and low phases each at least 3 clk periods.
- States:
  - IDLE -> ACTIVE on synchronized cs_n falling. In that cycle: tx_shift<=tx_data, bit_cnt<=0, busy<=1, miso<=tx_data[DATA_W-1].
  - ACTIVE -> IDLE on synchronized cs_n rising. In that cycle: busy<=0, miso<=0. If bit_cnt!=0, frame_err pulses for 1 cycle and rx_data is left unchanged.
  - Any sck edge detected in the same cycle as the cs_n rise is ignored (cs_n has priority).
- Receive, ACTIVE only, on synchronized sck rising:
  - rx_shift<={rx_shift[DATA_W-2:0], mosi_sync}, bit_cnt++.
  - When bit_cnt==DATA_W-1, the word is complete:
    - rx_data<=assembled word and rx_valid<=1 on the next clk edge;
    - bit_cnt wraps to 0, so multi-word frames continue without deasserting cs_n.
- Receive latency: rx_valid rises SYNC_STAGES+2 clk edges after the first clk edge that samples the last sck rising edge high.
- Transmit, ACTIVE only, on synchronized sck falling:
  - if bit_cnt==0 (word boundary, excluding the first word): tx_shift<=tx_data;
  - otherwise tx_shift shifts left by one;
  - miso always equals tx_shift[DATA_W-1].
- Ignored conditions:
  - sck edges while in IDLE.
  - The sck falling edge that precedes the first rising edge of a frame.
- Overrun: rx_valid is not back-pressured. The consumer must take rx_data within DATA_W sck periods.

Decomposition:
- Package spi_pkg:
  - SPI_DATA_W default, SPI_SYNC_STAGES default;
  - state enum {ST_IDLE, ST_ACTIVE};
  - sck/cs_n idle-level constants.
  - spi_master imports the same package.
- Sub-module spi_sync_edge:
  - parameterised SYNC_STAGES synchronizer plus edge detector;
  - outputs: level, rise, fall;
  - instantiated for sck and cs_n; mosi uses it for the level only.
- Remaining logic is one FSM with bit counter and shift registers; target 150-250 lines.

Test Plan:
- Reset, then idle 20 cycles with sck toggling and cs_n=1 -> rx_valid, frame_err, busy and miso all stay 0.
- Master sends 0xA5 with tx_data=0x5A -> busy rises after cs_n falls. rx_valid pulses exactly once with rx_data=0xA5. The sampled miso bits read 0x5A.
- Two-word frame 0xA5 then 0x3C under one cs_n, tx_data changed from 0x11 to 0x22 after the first rx_valid -> two rx_valid pulses (0xA5, 0x3C). miso carries 0x11 then 0x22. frame_err stays 0.
- cs_n raised after 3 sck rising edges -> frame_err pulses for 1 cycle, no rx_valid, rx_data keeps its previous value, busy=0.
- rst asserted after 5 bits of 0x3C, then released and 0xC3 sent -> all outputs are 0 during reset, no pulses for the aborted frame, next frame gives rx_data=0xC3.
- sck phases of exactly 3 clk cycles, data 0xFF then 0x00 -> both words received correctly. rx_valid latency is SYNC_STAGES+2 clk cycles from the final sck rising edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: default widths, FSM state encoding and line idle levels.
// Imported by both spi_slave and spi_master.
package spi_pkg;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_t;

  localparam logic SCK_IDLE_LEVEL  = 1'b0;
  localparam logic CS_N_IDLE_LEVEL = 1'b1;
  localparam logic MOSI_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input plus a registered edge detector.
// Reset loads every stage with the line's idle level so reset never creates an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  assign level = chain[SYNC_STAGES-1];

  // Edge flags are registered, so they trail the synchronized level by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{IDLE_LEVEL}};
      prev  <= IDLE_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled sck/cs_n/mosi, MSB-first receive with a valid strobe,
// and a reply word shifted out on miso.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level;

  spi_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic              word_done;
  logic              first_bit;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(SCK_IDLE_LEVEL)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck), .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(CS_N_IDLE_LEVEL)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n), .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(MOSI_IDLE_LEVEL)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_level), .rise(), .fall()
  );

  // The sck fall preceding the first rise of a frame is skipped via first_bit;
  // a completed word is published one cycle after its last bit is shifted in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      miso      <= 1'b0;
      word_done <= 1'b0;
      first_bit <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      word_done <= 1'b0;

      if (word_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state     <= ST_ACTIVE;
            tx_shift  <= tx_data;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            miso      <= tx_data[DATA_W-1];
            first_bit <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
            if (bit_cnt != '0) frame_err <= 1'b1;
          end else if (sck_rise) begin
            rx_shift  <= {rx_shift[DATA_W-2:0], mosi_level};
            first_bit <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall && !first_bit) begin
            if (bit_cnt == '0) begin
              tx_shift <= tx_data;
              miso     <= tx_data[DATA_W-1];
            end else begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              miso     <= tx_shift[DATA_W-2];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only the registered edge flags drive the FSM; the raw levels are kept for observability.
  logic unused_levels;
  assign unused_levels = sck_level ^ cs_level;

endmodule
